truth_table_sweeper: RTL

//  Exhaustive stimulus/response stage wrapped around the 4-input fig42 combinational block.
//  - Upstream side: drives abcd_out through 0..15 in order.
//  - Downstream side: waits for the block to settle, then samples f1/f2 into two 16-bit tables.
//  - Compares each sample against golden masks and reports pass/fail, mismatch count and first failing vector.
//  - Replaces the free-running #20 stimulus loop with a clocked, synthesizable sweep.

---
 rtl/truth_table_sweeper.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: clocked exhaustive sweep of a 4-input block.
// Drives ABCD 0..15, samples f1/f2 after settling, checks golden masks.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          1-cycle pulse, begins a sweep from IDLE or DONE
//   abort          synchronous abort, returns to IDLE, results held
//   f1, f2         responses of the combinational block
//   abcd_out       vector to the block (bit3=A .. bit0=D)
//   busy           high in DRIVE/SETTLE/SAMPLE
//   done           high in DONE
//   pass           high in DONE when no vector mismatched
//   err_cnt        number of mismatching vectors (0..16)
//   first_fail_idx index of first mismatching vector
//   first_fail_vld a mismatch has been recorded
//   f1_tab, f2_tab captured response tables, bit i = response to ABCD=i

module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [15:0] EXP_F1     = 16'hC0AA,
    parameter logic [15:0] EXP_F2     = 16'hC055
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        f1,
    input  logic        f2,
    output logic [3:0]  abcd_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_cnt,
    output logic [3:0]  first_fail_idx,
    output logic        first_fail_vld,
    output logic [15:0] f1_tab,
    output logic [15:0] f2_tab
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // Last value of the settle counter before moving to SAMPLE.
    localparam logic [3:0] SETTLE_LAST =
        (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_settle_cnt;
    logic [3:0]  r_abcd;
    logic [15:0] r_f1_tab;
    logic [15:0] r_f2_tab;
    logic [4:0]  r_err_cnt;
    logic [3:0]  r_ff_idx;
    logic        r_ff_vld;

    logic        w_start_ok;
    logic        w_sample;
    logic        w_exp_f1;
    logic        w_exp_f2;
    logic        w_mismatch;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides everything, including start.
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) w_next = S_DRIVE;
                end
                S_DRIVE: begin
                    w_next = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) w_next = S_SAMPLE;
                end
                S_SAMPLE: begin
                    w_next = (r_abcd == 4'hF) ? S_DONE : S_DRIVE;
                end
                S_DONE: begin
                    if (start) w_next = S_DRIVE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (r_state)
            S_DRIVE, S_SETTLE, S_SAMPLE: busy = 1'b1;
            S_DONE: begin
                done = 1'b1;
                pass = (r_err_cnt == 5'd0);
            end
            default: ;
        endcase
    end

    // Datapath control
    assign w_start_ok = start && !abort &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_sample   = !abort && (r_state == S_SAMPLE);
    assign w_exp_f1   = EXP_F1[r_abcd];
    assign w_exp_f2   = EXP_F2[r_abcd];
    assign w_mismatch = (f1 != w_exp_f1) || (f2 != w_exp_f2);

    // Settle counter restarts on every DRIVE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= 4'd0;
        end else if (r_state == S_DRIVE) begin
            r_settle_cnt <= 4'd0;
        end else if (r_state == S_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
        end
    end

    // Vector, tables and error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abcd    <= 4'd0;
            r_f1_tab  <= 16'd0;
            r_f2_tab  <= 16'd0;
            r_err_cnt <= 5'd0;
            r_ff_idx  <= 4'd0;
            r_ff_vld  <= 1'b0;
        end else if (w_start_ok) begin
            r_abcd    <= 4'd0;
            r_f1_tab  <= 16'd0;
            r_f2_tab  <= 16'd0;
            r_err_cnt <= 5'd0;
            r_ff_idx  <= 4'd0;
            r_ff_vld  <= 1'b0;
        end else if (w_sample) begin
            r_f1_tab[r_abcd] <= f1;
            r_f2_tab[r_abcd] <= f2;
            if (w_mismatch) begin
                r_err_cnt <= r_err_cnt + 5'd1;
                if (!r_ff_vld) begin
                    r_ff_idx <= r_abcd;
                    r_ff_vld <= 1'b1;
                end
            end
            // Vector 15 is held; wrap to 0 only via restart.
            if (r_abcd != 4'hF) begin
                r_abcd <= r_abcd + 4'd1;
            end
        end
    end

    assign abcd_out       = r_abcd;
    assign err_cnt        = r_err_cnt;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_vld = r_ff_vld;
    assign f1_tab         = r_f1_tab;
    assign f2_tab         = r_f2_tab;

endmodule
